uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered UART transmitter on the mips32r1_soc peripheral side, downstream of the CPU data bus.
//  - Accepts bytes written by the CPU (nmon console output) into a synchronous FIFO.
//  - Serialises them 8N1, LSB first, onto the board TX pin.
//  - Default rate is 9600 baud from the 10 MHz system clock.
//  - Status outputs let software poll before writing.
// PARAMETERS
//  CLK_FREQ    10_000_000  system clock frequency in Hz
//  BAUD        9600        line rate in bit/s
//  FIFO_AW     4           FIFO address width; depth = 2**FIFO_AW (16) entries
// PORTS
//  clock     in   1          system clock; all logic is on the rising edge
//  reset     in   1          synchronous, active-high; flushes FIFO, aborts frame
//  wr_en     in   1          one-cycle write strobe from the bus decoder
//  wr_data   in   8          byte to transmit, sampled when wr_en=1
//  clr_ovf   in   1          clears the sticky overflow flag
//  tx        out  1          serial line; idles high
//  full      out  1          FIFO holds 2**FIFO_AW entries (registered)
//  empty     out  1          FIFO holds 0 entries (registered)
//  level     out  FIFO_AW+1  current FIFO occupancy
//  busy      out  1          1 while a frame is on the line (FSM not in IDLE)
//  ovf       out  1          sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values (cycle after reset=1): tx=1, full=0, empty=1, level=0, busy=0, ovf=0.
//  Reset mid-frame: tx=1 on the next edge, state IDLE, FIFO pointers zeroed. No partial frame resumes.
//  Baud divisor: DIV = (CLK_FREQ + BAUD/2) / BAUD, computed at elaboration.
//   - Default DIV = 1042.
//   - Counter width = clog2(DIV). It counts 0..DIV-1 inside each bit period.
//  Write side: a write is accepted iff wr_en=1 and full=0, using the registered full.
//   - A pop in the same cycle does not make room for a write in that cycle.
//   - A write while full=1 is dropped and sets ovf=1. clr_ovf=1 clears ovf.
//   - If a dropped write and clr_ovf coincide, ovf is set (set wins).
//  FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If empty=0, pop the head byte into the shift register and go to START.
//   - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
//   - DATA: tx=shreg[0] for DIV cycles, then shift right. After bit 7, go to STOP.
//   - STOP: tx=1 for DIV cycles. At the last cycle, if empty=0, pop and go directly to START
//     (back-to-back frames, no idle gap); otherwise go to IDLE.
//  Frame length: exactly 10*DIV cycles.
//  Latency: wr_en at edge N into an empty FIFO with the FSM in IDLE.
//   - empty=0 at N+1. The IDLE pop occurs at edge N+1.
//   - tx falls at edge N+2.
//  Simultaneous write and pop:
//   - Accepted write plus pop leaves level unchanged.
//   - A write into an empty FIFO is not forwarded in the same cycle.
//  Pointers wrap modulo 2**FIFO_AW. Level is tracked separately (FIFO_AW+1 bits) so full and empty are unambiguous.
//  tx is driven directly from a register (glitch-free).
// STRUCTURE
//  Include file uart_defs.vh holds:
//   - FSM state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
//   - The divisor rounding macro, shared with the future uart_rx.
//  Sub-module sync_fifo (params DW=8, AW=FIFO_AW):
//   - Ports push, pop, din, dout, full, empty, level.
//   - dout shows the head entry combinationally (first-word fall-through) so the IDLE pop latches it the same edge.
//  Top level contains: the baud counter, bit index, shift register, FSM and ovf flag.
// TESTING (sim params CLK_FREQ=10_000_000, BAUD=1_000_000, so DIV=10)
//  1 Reset: hold reset 3 cycles, then release.
//    -> tx=1, empty=1, level=0, busy=0, ovf=0. tx stays 1 for 200 cycles with no writes.
//  2 Single byte 0xA5 written at cycle N.
//    -> tx=0 from N+2 for 10 cycles, then data bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop=1.
//    -> busy=0 at N+2+100. Bench UART model decodes 0xA5.
//  3 Burst of 0x55, 0x0F, 0xFF in consecutive cycles.
//    -> level peaks at 2 (the first byte is popped at once). Frames are contiguous: the next start bit
//       follows the stop bit with no gap. Total 300 cycles from the first falling edge.
//  4 Overflow: with the FSM mid-frame, write 17 bytes back-to-back.
//    -> 16 accepted, full=1, ovf=1. The 17th byte never appears on tx.
//    -> clr_ovf pulse -> ovf=0, full unchanged.
//  5 Reset mid-frame: write 0x3C, assert reset at bit 4 of DATA.
//    -> tx=1 next cycle, level=0. No further edges on tx within 200 cycles.
//  6 Write coinciding with the STOP-end pop at level=1.
//    -> level stays 1, both bytes are transmitted in order, no byte is lost or duplicated.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared FSM encoding and baud divisor helper for the UART blocks
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Rounded to the nearest integer so the rate error stays symmetric.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - CPU write/status and serial line bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               clr_ovf;
    logic               tx;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   level;
    logic               busy;
    logic               ovf;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  tx, full, empty, level, busy, ovf
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output tx, full, empty, level, busy, ovf
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - synchronous first-word fall-through FIFO with registered flags
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          push_ok, pop_ok;

    // Flags are registered, so a same-cycle pop never frees room for a push.
    always_comb begin
        push_ok  = push_i & ~full_q;
        pop_ok   = pop_i & ~empty_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_d   = (level_d == DEPTH);
        empty_d  = (level_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter: FIFO, baud counter, shifter and FSM
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_tx_fifo_if.slave  bus
);
    localparam int             DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;
    logic           pop, bit_end;
    logic [7:0]     fifo_dout;
    logic           fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_level;

    sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.wr_en & ~fifo_full),
        .pop_i   (pop),
        .din_i   (bus.wr_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        bit_end = (cnt_q == CNT_LAST);
        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                shreg_d = fifo_dout;
                cnt_d   = '0;
                state_d = ST_START;
            end
            ST_START: if (bit_end) begin
                bit_d   = 3'd0;
                state_d = ST_DATA;
            end
            ST_DATA: if (bit_end) begin
                shreg_d = {1'b0, shreg_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: if (bit_end) begin
                // Chain straight into the next start bit when more data is waiting.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_q[0];
            default:  tx_d = 1'b1;
        endcase

        ovf_d = ovf_q;
        if (bus.wr_en && fifo_full) ovf_d = 1'b1;
        else if (bus.clr_ovf)       ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.tx    = tx_q;
    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;
    assign bus.level = fifo_level;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a line-decoding UART model
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 10_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int FIFO_AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(FIFO_AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         mon_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Line model: mid-bit sampling of each frame, decoded byte popped against the scoreboard.
    initial begin
        int         mon_cnt;
        int         k;
        logic [7:0] mon_byte;
        mon_cnt  = 0;
        mon_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (bus.tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % 10 == 5) begin
                    k = mon_cnt / 10;
                    if (k == 0) begin
                        check("mon_start_bit", 32'(bus.tx), 32'd0);
                    end else if (k <= 8) begin
                        mon_byte[k-1] = bus.tx;
                    end else begin
                        check("mon_stop_bit", 32'(bus.tx), 32'd1);
                        check("mon_frame_expected", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) check("mon_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] data, input bit on_line);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        if (on_line) exp_q.push_back(data);
        tick(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1 && !mon_active) && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (bus.tx !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < 50), 32'd1);
    endtask

    task automatic count_tx_low(input string tag, input int cycles);
        int lows = 0;
        repeat (cycles) begin
            tick(1);
            if (bus.tx !== 1'b1) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       exp_bit;
        int         peak;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;

        // 1: reset state and quiet line
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("rst_tx",    32'(bus.tx),    32'd1);
        check("rst_full",  32'(bus.full),  32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_ovf",   32'(bus.ovf),   32'd0);
        count_tx_low("idle_tx_low_cycles", 200);

        // 2: single byte latency and bit pattern
        b = 8'hA5;
        write_byte(b, 1'b1);
        check("t2_empty_n1", 32'(bus.empty), 32'd0);
        check("t2_level_n1", 32'(bus.level), 32'd1);
        check("t2_tx_n1",    32'(bus.tx),    32'd1);
        tick(1);
        check("t2_tx_n2",    32'(bus.tx),    32'd1);
        check("t2_busy_n2",  32'(bus.busy),  32'd1);
        tick(1);
        check("t2_tx_fall",  32'(bus.tx),    32'd0);
        for (int k = 0; k < 10; k++) begin
            tick(k == 0 ? 5 : 10);
            if (k == 0)      exp_bit = 1'b0;
            else if (k == 9) exp_bit = 1'b1;
            else             exp_bit = b[k-1];
            check($sformatf("t2_bit%0d", k), 32'(bus.tx), 32'(exp_bit));
        end
        tick(3);
        check("t2_busy_last", 32'(bus.busy), 32'd1);
        tick(2);
        check("t2_busy_done", 32'(bus.busy), 32'd0);

        // 3: burst, level peak and contiguous frames
        wait_idle("t3_idle_timeout");
        start_q.delete();
        peak = 0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h55; exp_q.push_back(8'h55); tick(1);
        if (int'(bus.level) > peak) peak = int'(bus.level);
        bus.wr_data = 8'h0F; exp_q.push_back(8'h0F); tick(1);
        if (int'(bus.level) > peak) peak = int'(bus.level);
        bus.wr_data = 8'hFF; exp_q.push_back(8'hFF); tick(1);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (int'(bus.level) > peak) peak = int'(bus.level);
            tick(1);
        end
        check("t3_level_peak", 32'(peak), 32'd2);
        wait_idle("t3_drain_timeout");
        check("t3_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("t3_gap01", 32'(start_q[1] - start_q[0]), 32'd100);
            check("t3_gap12", 32'(start_q[2] - start_q[1]), 32'd100);
        end

        // 4: overflow while a frame is on the line
        wait_idle("t4_idle_timeout");
        write_byte(8'h11, 1'b1);
        wait_tx_low("t4_fall_timeout");
        for (int i = 0; i < 17; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h80 + i);
            if (i < 16) exp_q.push_back(8'(8'h80 + i));
            tick(1);
        end
        bus.wr_en = 1'b0;
        check("t4_full",  32'(bus.full),  32'd1);
        check("t4_ovf",   32'(bus.ovf),   32'd1);
        check("t4_level", 32'(bus.level), 32'd16);
        bus.clr_ovf = 1'b1; tick(1); bus.clr_ovf = 1'b0;
        check("t4_ovf_cleared",  32'(bus.ovf),  32'd0);
        check("t4_full_kept",    32'(bus.full), 32'd1);
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.clr_ovf = 1'b1;
        tick(1);
        bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
        check("t4_ovf_set_wins", 32'(bus.ovf),   32'd1);
        check("t4_level_drop",   32'(bus.level), 32'd16);
        bus.clr_ovf = 1'b1; tick(1); bus.clr_ovf = 1'b0;
        check("t4_ovf_cleared2", 32'(bus.ovf), 32'd0);
        wait_idle("t4_drain_timeout");

        // 5: reset during data bit 4
        write_byte(8'h3C, 1'b0);
        wait_tx_low("t5_fall_timeout");
        tick(52);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_tx",    32'(bus.tx),    32'd1);
        check("t5_level", 32'(bus.level), 32'd0);
        check("t5_busy",  32'(bus.busy),  32'd0);
        count_tx_low("t5_tx_low_cycles", 200);

        // 6: write coinciding with the stop-end pop
        wait_idle("t6_idle_timeout");
        write_byte(8'h61, 1'b1);
        write_byte(8'h62, 1'b1);
        tick(1);
        check("t6_fall",   32'(bus.tx),    32'd0);
        check("t6_level0", 32'(bus.level), 32'd1);
        tick(98);
        write_byte(8'h63, 1'b1);
        check("t6_level_hold", 32'(bus.level), 32'd1);
        check("t6_busy",       32'(bus.busy),  32'd1);
        wait_idle("t6_drain_timeout");

        tick(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
